// File: rtl/output_uart_tx_pkg.sv
// output_uart_tx_pkg: output port IDs, UART state encoding and default bit timing
package output_uart_tx_pkg;
  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/output_uart_tx_sync_fifo.sv
// output_uart_tx_sync_fifo: show-ahead sync FIFO (push/pop/din -> dout/full/empty/count), sync active-high reset
module output_uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(do_push);
      rptr_q <= rptr_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/output_uart_tx.sv
// output_uart_tx: 8N1 UART transmitter fed by CPU output-port writes (we/sel_port/in_RD2 -> FIFO -> tx; status busy/full/empty/overflow)
module output_uart_tx
  import output_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4,
  parameter logic [1:0] PORT_ID = P3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] sel_port,
  input  logic [7:0] in_RD2,
  input  logic       clr_overflow,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       overflow
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  uart_state_e state_q;
  logic [BW-1:0] baud_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q, dout;
  logic tx_q, busy_q, ovf_q, ovf_d;
  logic wr, push, pop, bit_end, f_full, f_empty;
  logic [CW-1:0] count;
  assign wr = we && sel_port == PORT_ID;
  assign push = wr && !f_full;
  assign bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
  // the next byte is taken either from idle or straight at the end of a stop bit, so frames abut
  assign pop = !f_empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign ovf_d = (wr && f_full) || (ovf_q && !clr_overflow);
  assign tx = tx_q;
  assign tx_busy = busy_q;
  assign fifo_full = count == CW'(FIFO_DEPTH);
  assign fifo_empty = count == '0;
  assign overflow = ovf_q;
  output_uart_tx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(in_RD2),
    .dout(dout), .full(f_full), .empty(f_empty), .count(count)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: if (pop) begin
          shift_q <= dout;
          tx_q <= 1'b0;
          busy_q <= 1'b1;
          state_q <= START;
        end
        START: if (bit_end) begin
          tx_q <= shift_q[0];
          shift_q <= shift_q >> 1;
          bit_q <= '0;
          state_q <= DATA;
        end
        DATA: if (bit_end) begin
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            tx_q <= 1'b1;
            state_q <= STOP;
          end else begin
            tx_q <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        STOP: if (bit_end) begin
          if (pop) begin
            shift_q <= dout;
            tx_q <= 1'b0;
            state_q <= START;
          end else begin
            tx_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_uart_tx.sv
// tb_output_uart_tx: directed scoreboard bench decoding tx frames against queued expected bytes
module tb_output_uart_tx;
  logic clk = 0, reset = 1, we = 0, clr_overflow = 0;
  logic [1:0] sel_port = 0;
  logic [7:0] in_RD2 = 0;
  logic tx, tx_busy, fifo_full, fifo_empty, overflow;
  int checks = 0, errors = 0, frames = 0, cyc = 0;
  logic [7:0] sb[$];
  int starts[$];

  output_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PORT_ID(2'd3)) dut (
    .clk(clk), .reset(reset), .we(we), .sel_port(sel_port), .in_RD2(in_RD2),
    .clr_overflow(clr_overflow), .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] p, input logic [7:0] d);
    @(negedge clk);
    we = 1;
    sel_port = p;
    in_RD2 = d;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    we = 0;
    clr_overflow = 0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("frame_timeout", 32'(frames >= n), 1);
    repeat (3) @(negedge clk);
  endtask

  // frame decoder: sample mid-bit on falling edges, abort on reset
  initial forever begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      logic [7:0] d;
      logic sbit, pbit, abort;
      logic [7:0] e;
      d = 0;
      sbit = 1;
      pbit = 0;
      abort = 0;
      starts.push_back(cyc);
      for (int k = 1; k < 40; k++) begin
        @(negedge clk);
        if (reset) begin
          abort = 1;
          break;
        end
        if (k == 2) sbit = tx;
        if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) d[(k-6)/4] = tx;
        if (k == 38) pbit = tx;
      end
      if (!abort) begin
        chk("start_bit", 32'(sbit), 0);
        chk("stop_bit", 32'(pbit), 1);
        if (sb.size() == 0) chk("unexpected_frame", 32'(d), 32'hFFFF);
        else begin
          e = sb.pop_front();
          chk("frame_data", 32'(d), 32'(e));
        end
        frames++;
      end
    end
  end

  initial begin
    int wcyc, n, f0, s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 0;
    repeat (2) @(negedge clk);

    // single frame 0xA5: latency and busy length
    wr(2'd3, 8'hA5);
    sb.push_back(8'hA5);
    idle_bus();
    wcyc = cyc;
    chk("a5_tx_before", 32'(tx), 1);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_busy) n++;
    end
    chk("a5_busy_cycles", 32'(n), 40);
    chk("a5_frames", 32'(frames), 1);
    chk("a5_start_cycle", 32'(starts[0]), 32'(wcyc + 1));

    // ignored writes
    f0 = frames;
    wr(2'd0, 8'h11);
    wr(2'd1, 8'h22);
    wr(2'd2, 8'h33);
    idle_bus();
    sel_port = 2'd3;
    in_RD2 = 8'h44;
    @(negedge clk);
    chk("ign_empty", 32'(fifo_empty), 1);
    chk("ign_busy", 32'(tx_busy), 0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) n++;
    end
    chk("ign_tx_idle", 32'(n), 0);
    chk("ign_frames", 32'(frames), 32'(f0));

    // burst of 6: one popped at once, four queued, last dropped
    f0 = frames;
    s = starts.size();
    for (int i = 1; i <= 6; i++) begin
      wr(2'd3, 8'(i));
      if (i <= 5) sb.push_back(8'(i));
    end
    idle_bus();
    wcyc = cyc;
    chk("burst_ovf", 32'(overflow), 1);
    chk("burst_full", 32'(fifo_full), 1);
    wait_frames(f0 + 5, 300);
    chk("burst_first_start", 32'(starts[s]), 32'(wcyc - 5 + 1));
    for (int i = s + 1; i < s + 5; i++) chk("burst_gap", 32'(starts[i] - starts[i-1]), 40);
    chk("burst_empty", 32'(fifo_empty), 1);
    chk("burst_ovf_sticky", 32'(overflow), 1);

    // overflow clear priority
    @(negedge clk);
    clr_overflow = 1;
    idle_bus();
    chk("clr_alone", 32'(overflow), 0);
    f0 = frames;
    for (int i = 0; i < 5; i++) begin
      wr(2'd3, 8'h10 + 8'(i));
      sb.push_back(8'h10 + 8'(i));
    end
    wr(2'd3, 8'h15);
    clr_overflow = 1;
    idle_bus();
    chk("set_beats_clr", 32'(overflow), 1);
    @(negedge clk);
    clr_overflow = 1;
    idle_bus();
    chk("clr_later", 32'(overflow), 0);
    wait_frames(f0 + 5, 300);

    // reset during DATA bit 3 of first of three queued bytes
    wr(2'd3, 8'h31);
    sb.push_back(8'h31);
    wr(2'd3, 8'h32);
    sb.push_back(8'h32);
    wr(2'd3, 8'h33);
    sb.push_back(8'h33);
    idle_bus();
    repeat (15) @(negedge clk);
    chk("abort_bit3", 32'(tx), 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    sb.delete();
    chk("abort_tx", 32'(tx), 1);
    chk("abort_empty", 32'(fifo_empty), 1);
    chk("abort_busy", 32'(tx_busy), 0);
    f0 = frames;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) n++;
    end
    chk("abort_quiet", 32'(n), 0);
    chk("abort_frames", 32'(frames), 32'(f0));
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
